snake_collision_ctrl: RTL
=========================

Name: snake_collision_ctrl

Overview:
- Consumes the registered per-pixel activity flags of the snake head, snake body and apple, together with the beam position.
- Detects head/apple, head/body and head/border overlaps during each frame.
- At frame end, publishes a 2-bit collision code and runs the game state machine.
- Drives the collision and game_state inputs of the snake drawing block, plus a score and an apple-respawn pulse.

Parameters:
- BIT, 10, width of x_pos/y_pos.
- H_RES, 640, visible width in pixels.
- V_RES, 480, visible height in pixels.
- BORDER, 10, playfield wall thickness in pixels.
- SCORE_W, 8, score counter width.
- GO_FRAMES, 60, minimum frames spent in GAME_OVER before restart is accepted.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high reset.
- x_pos  in  BIT  current beam column.
- y_pos  in  BIT  current beam row.
- video_active  in  1  beam is inside the visible area.
- frame_end  in  1  one-cycle pulse after the last visible pixel; the same pulse as the snake block's update.
- head_active  in  1  snake head pixel flag, registered one cycle behind x_pos/y_pos.
- body_active  in  1  snake body pixel flag, same one-cycle lag.
- apple_active  in  1  apple pixel flag, same one-cycle lag.
- start  in  1  debounced start button, level.
- collision  out  2  00 none, 01 fatal hit, 10 apple collected.
- game_state  out  2  00 IDLE, 01 PLAY, 11 GAME_OVER; 10 is never driven.
- score  out  SCORE_W  apples collected in the current game.
- apple_respawn  out  1  one-cycle pulse requesting a new apple position.

Behaviour:
- Reset (asynchronous, active-high), applied to every register:
  - game_state=IDLE, collision=00, score=0, apple_respawn=0.
  - All hit flags, the frame counter and the start edge register clear.
- Alignment: x_pos, y_pos and video_active are delayed by one register. All comparisons use the delayed copies, so they line up with the one-cycle-late activity flags.
- Per-frame hit flags: sticky, set only in PLAY while delayed video_active=1.
  - hit_apple: set on a cycle with head_active & apple_active.
  - hit_body: set on a cycle with head_active & body_active.
  - hit_wall: set on a cycle with head_active and (dx<BORDER | dx>=H_RES-BORDER | dy<BORDER | dy>=V_RES-BORDER).
- Frame-end evaluation: on the frame_end cycle, the flags are evaluated, including any flag set in that same cycle, and then cleared.
  - Fatal priority: hit_body|hit_wall -> collision=01 and game_state=GAME_OVER on the next cycle. An apple hit in the same frame is ignored, with no score change.
  - Apple only: collision=10, score+1 (saturates at all-ones), apple_respawn pulses once on the cycle after frame_end.
  - No hit: collision=00.
- Collision hold: collision is held for exactly one frame, i.e. until the next frame_end. This guarantees the snake block sees 10 then 00, once per apple.
- Game state machine:
  - IDLE: rising edge of start -> PLAY. score clears on this transition. The start edge register samples every cycle.
  - PLAY: fatal frame-end -> GAME_OVER. A start edge is ignored.
  - GAME_OVER: counts frame_end pulses up to GO_FRAMES. collision returns to 00 at the next frame_end and stays 00. After the count is reached, a start rising edge -> IDLE. An edge arriving earlier is discarded, not queued. score holds its final value until the next PLAY entry.
- Flag gating: the flags are not set outside PLAY. Flags left over from a frame that ends in a transition are cleared at that frame_end.
- Reset mid-frame or mid-GAME_OVER returns to IDLE immediately, asynchronously.
- Latency: collision and score are valid 1 cycle after frame_end. game_state changes 1 cycle after the frame_end or the start edge that causes it.

Test Plan:
- Reset, then start high for 3 cycles: game_state 00->01 exactly once; score=0; collision=00. Holding start does not retrigger.
- PLAY; head_active & apple_active coincide at (dx,dy)=(320,240) for 1 cycle, then frame_end: collision=10 for one frame, score=1, one apple_respawn pulse, collision=00 after the next frame_end.
- PLAY; head_active with delayed dx=5 (BORDER=10): at frame_end collision=01 and game_state=11. Check the delay: a flag raised while the undelayed x_pos=5 but delayed dx=15 must NOT hit.
- Same frame has an apple hit and a body hit: collision=01, score unchanged, no apple_respawn, game_state=11.
- GAME_OVER: start pulse after 10 frames is ignored; start pulse after 60 frame_end pulses -> IDLE; next start -> PLAY with score=0.
- score at 255 plus an apple: score stays 255 and collision=10. Assert reset mid-frame with hit_body set: all outputs are at reset values with no clock edge, and no collision after reset is released.

Source files
------------

// File: rtl/snake_collision_if.sv
// Bus between the video/game datapath and the snake collision controller.
// The master side drives the beam position, the per-pixel activity flags,
// the frame-end pulse and the start button. The slave side (the controller)
// returns the collision code, the game state, the score and the apple-respawn
// request.
//   x_pos, y_pos      beam column/row (BIT bits)
//   video_active      beam inside the visible area
//   frame_end         one-cycle pulse after the last visible pixel
//   head/body/apple_active  pixel flags, one cycle behind x_pos/y_pos
//   start             debounced start button (level)
//   collision         00 none, 01 fatal, 10 apple
//   game_state        00 IDLE, 01 PLAY, 11 GAME_OVER
//   score             apples collected in the current game
//   apple_respawn     one-cycle request for a new apple position
interface snake_collision_if #(
  parameter int BIT     = 10,
  parameter int SCORE_W = 8
);
  logic [BIT-1:0]     x_pos;
  logic [BIT-1:0]     y_pos;
  logic               video_active;
  logic               frame_end;
  logic               head_active;
  logic               body_active;
  logic               apple_active;
  logic               start;
  logic [1:0]         collision;
  logic [1:0]         game_state;
  logic [SCORE_W-1:0] score;
  logic               apple_respawn;

  modport master (
    output x_pos, y_pos, video_active, frame_end,
    output head_active, body_active, apple_active, start,
    input  collision, game_state, score, apple_respawn
  );

  modport slave (
    input  x_pos, y_pos, video_active, frame_end,
    input  head_active, body_active, apple_active, start,
    output collision, game_state, score, apple_respawn
  );
endinterface

// File: rtl/snake_collision_ctrl.sv
// Snake game collision detector and game state machine.
// Watches the snake head flag against the apple flag, the body flag and the
// playfield border during a frame, then at frame_end publishes a collision
// code (held for one frame), updates the score and advances the game state.
// Ports:
//   clk    system/pixel clock
//   reset  asynchronous, active-high reset of every register
//   bus    snake_collision_if slave modport (beam, flags, start in;
//          collision, game_state, score, apple_respawn out)
module snake_collision_ctrl #(
  parameter int BIT       = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BORDER    = 10,
  parameter int SCORE_W   = 8,
  parameter int GO_FRAMES = 60
) (
  input logic              clk,
  input logic              reset,
  snake_collision_if.slave bus
);

  localparam logic [BIT-1:0] X_LO = BIT'(BORDER);
  localparam logic [BIT-1:0] X_HI = BIT'(H_RES - BORDER);
  localparam logic [BIT-1:0] Y_LO = BIT'(BORDER);
  localparam logic [BIT-1:0] Y_HI = BIT'(V_RES - BORDER);

  localparam int             GO_W    = $clog2(GO_FRAMES + 1);
  localparam logic [GO_W-1:0] GO_DONE = GO_W'(GO_FRAMES);

  localparam logic [1:0] COL_NONE  = 2'b00;
  localparam logic [1:0] COL_FATAL = 2'b01;
  localparam logic [1:0] COL_APPLE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b11
  } state_t;

  state_t             state_r;
  logic [BIT-1:0]     dx_r;
  logic [BIT-1:0]     dy_r;
  logic               dva_r;
  logic               start_d_r;
  logic               hit_apple_r;
  logic               hit_body_r;
  logic               hit_wall_r;
  logic [GO_W-1:0]    go_cnt_r;
  logic [1:0]         collision_r;
  logic [SCORE_W-1:0] score_r;
  logic               apple_respawn_r;

  logic start_edge_s;
  logic in_play_s;
  logic at_wall_s;
  logic set_apple_s;
  logic set_body_s;
  logic set_wall_s;
  logic fatal_s;
  logic apple_s;

  // Hit detection on the delayed beam position, plus frame-end verdicts that
  // fold in any hit raised on the frame_end cycle itself.
  always_comb begin
    start_edge_s = bus.start & ~start_d_r;
    in_play_s    = (state_r == ST_PLAY) & dva_r;
    at_wall_s    = (dx_r < X_LO) | (dx_r >= X_HI) | (dy_r < Y_LO) | (dy_r >= Y_HI);
    set_apple_s  = in_play_s & bus.head_active & bus.apple_active;
    set_body_s   = in_play_s & bus.head_active & bus.body_active;
    set_wall_s   = in_play_s & bus.head_active & at_wall_s;
    fatal_s      = hit_body_r | hit_wall_r | set_body_s | set_wall_s;
    apple_s      = hit_apple_r | set_apple_s;
  end

  // Alignment registers, sticky hit flags, game state machine and all outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      dx_r            <= '0;
      dy_r            <= '0;
      dva_r           <= 1'b0;
      start_d_r       <= 1'b0;
      hit_apple_r     <= 1'b0;
      hit_body_r      <= 1'b0;
      hit_wall_r      <= 1'b0;
      go_cnt_r        <= '0;
      collision_r     <= COL_NONE;
      score_r         <= '0;
      apple_respawn_r <= 1'b0;
    end else begin
      dx_r            <= bus.x_pos;
      dy_r            <= bus.y_pos;
      dva_r           <= bus.video_active;
      start_d_r       <= bus.start;
      apple_respawn_r <= 1'b0;

      // Flags collect over one frame and are consumed at its end.
      if (bus.frame_end) begin
        hit_apple_r <= 1'b0;
        hit_body_r  <= 1'b0;
        hit_wall_r  <= 1'b0;
      end else begin
        hit_apple_r <= hit_apple_r | set_apple_s;
        hit_body_r  <= hit_body_r | set_body_s;
        hit_wall_r  <= hit_wall_r | set_wall_s;
      end

      case (state_r)
        ST_IDLE: begin
          if (bus.frame_end) begin
            collision_r <= COL_NONE;
          end
          if (start_edge_s) begin
            state_r <= ST_PLAY;
            score_r <= '0;
          end
        end
        ST_PLAY: begin
          if (bus.frame_end) begin
            if (fatal_s) begin
              // A fatal hit overrides an apple taken in the same frame.
              collision_r <= COL_FATAL;
              state_r     <= ST_OVER;
              go_cnt_r    <= '0;
            end else if (apple_s) begin
              collision_r     <= COL_APPLE;
              apple_respawn_r <= 1'b1;
              if (score_r != {SCORE_W{1'b1}}) begin
                score_r <= score_r + SCORE_W'(1);
              end
            end else begin
              collision_r <= COL_NONE;
            end
          end
        end
        ST_OVER: begin
          if (bus.frame_end) begin
            collision_r <= COL_NONE;
            if (go_cnt_r != GO_DONE) begin
              go_cnt_r <= go_cnt_r + GO_W'(1);
            end
          end
          // Early edges are simply lost: the edge only exists for one cycle.
          if (start_edge_s && (go_cnt_r == GO_DONE)) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          collision_r <= COL_NONE;
        end
      endcase
    end
  end

  assign bus.collision     = collision_r;
  assign bus.game_state    = state_r;
  assign bus.score         = score_r;
  assign bus.apple_respawn = apple_respawn_r;

endmodule
